d_ff: RTL and testbench

D_FF -- requirements
Module: d_ff

---
 rtl/d_ff_pkg.sv | 12 +
 rtl/d_ff.sv | 47 ++++
 tb/tb_d_ff.sv | 131 +++++++++++++
 3 files changed

// File: rtl/d_ff_pkg.sv
// Shared constants for the d_ff register: default and maximum data width,
// plus the width legality check used at elaboration.
package d_ff_pkg;

  localparam int D_FF_DEFAULT_WIDTH = 1;
  localparam int D_FF_MAX_WIDTH     = 64;

  function automatic bit d_ff_width_ok(input int w);
    return (w >= 1) && (w <= D_FF_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/d_ff.sv
// WIDTH-bit D flip-flop with synchronous active-high reset (n_rst) to RST_VAL
// and a combinational complement output. Define D_FF_ASSERT_EN for sim checks.
module d_ff
  import d_ff_pkg::*;
#(
  parameter int               WIDTH   = D_FF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CP,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  if (!d_ff_width_ok(WIDTH)) begin : g_bad_width
    $error("d_ff: WIDTH %0d outside 1..%0d", WIDTH, D_FF_MAX_WIDTH);
  end

  logic [WIDTH-1:0] r_q;

  // n_rst is active-high despite its name; reset takes priority over D.
  always_ff @(posedge CP) begin
    if (n_rst) r_q <= RST_VAL;
    else       r_q <= D;
  end

  assign Q    = r_q;
  assign Qbar = ~r_q;

`ifdef D_FF_ASSERT_EN
  logic r_rst_prev;

  always_ff @(posedge CP) begin
    r_rst_prev <= (n_rst === 1'b1);
    if (Qbar !== ~Q)
      $error("%0t d_ff: Qbar %h is not ~Q %h", $time, Qbar, Q);
    if ($isunknown(n_rst))
      $error("%0t d_ff: n_rst is X/Z", $time);
    if ((n_rst === 1'b0) && $isunknown(D))
      $error("%0t d_ff: D is X/Z while loading", $time);
    if (r_rst_prev && (Q !== RST_VAL))
      $error("%0t d_ff: Q %h not RST_VAL %h after reset", $time, Q, RST_VAL);
  end
`endif

endmodule

// File: tb/tb_d_ff.sv
// Scoreboard bench for d_ff: a 1-bit and an 8-bit (RST_VAL=A5) instance share
// clock and reset; mid-cycle glitches on D/n_rst must never reach Q.
module tb_d_ff;

  logic       CP;
  logic       n_rst;
  logic       d1;
  logic [7:0] d8;
  logic       q1, qb1;
  logic [7:0] q8, qb8;

  localparam logic [7:0] RST8 = 8'hA5;

  d_ff u_dut1 (.CP(CP), .n_rst(n_rst), .D(d1), .Q(q1), .Qbar(qb1));

  d_ff #(.WIDTH(8), .RST_VAL(RST8)) u_dut8 (
    .CP(CP), .n_rst(n_rst), .D(d8), .Q(q8), .Qbar(qb8)
  );

  initial begin
    CP = 1'b0;
    forever #2 CP = ~CP;
  end

  typedef struct {
    logic       q1;
    logic [7:0] q8;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: whatever is on the pins at the edge decides the next Q.
  function automatic exp_t model(input logic rst, input logic v1, input logic [7:0] v8);
    exp_t e;
    e.q1 = rst ? 1'b0 : v1;
    e.q8 = rst ? RST8 : v8;
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: new value one unit after each edge, then a hold check mid-cycle
  // after any glitch has been applied.
  initial begin
    exp_t cur;
    bit   have;
    have = 1'b0;
    forever begin
      @(posedge CP);
      #1;
      if (sb.size() > 0) begin
        cur  = sb.pop_front();
        have = 1'b1;
        chk("q1",    {7'b0, q1},  {7'b0, cur.q1});
        chk("qbar1", {7'b0, qb1}, {7'b0, ~cur.q1});
        chk("q8",    q8,  cur.q8);
        chk("qbar8", qb8, ~cur.q8);
      end
      #1;
      if (have) begin
        chk("hold_q1", {7'b0, q1}, {7'b0, cur.q1});
        chk("hold_q8", q8, cur.q8);
      end
    end
  end

  // Entered one unit after a rising edge. Optional glitch values are driven
  // mid-cycle, then the final values one unit before the next edge.
  task automatic cycle(input bit g, input logic gr, input logic gd1, input logic [7:0] gd8,
                       input logic r, input logic v1, input logic [7:0] v8);
    if (g) begin
      n_rst = gr;
      d1    = gd1;
      d8    = gd8;
    end
    #2;
    n_rst = r;
    d1    = v1;
    d8    = v8;
    sb.push_back(model(r, v1, v8));
    @(posedge CP);
    #1;
  endtask

  initial begin
    // First edge samples reset with D=1.
    n_rst = 1'b1;
    d1    = 1'b1;
    d8    = 8'hFF;
    sb.push_back(model(1'b1, 1'b1, 8'hFF));
    @(posedge CP);
    #1;

    cycle(0, 0, 0, 8'h00, 1'b1, 1'b1, 8'h77);   // reset held
    cycle(0, 0, 0, 8'h00, 1'b0, 1'b1, 8'h3C);   // first load after release
    cycle(0, 0, 0, 8'h00, 1'b0, 1'b0, 8'h55);
    cycle(0, 0, 0, 8'h00, 1'b0, 1'b1, 8'h81);
    cycle(1, 0, 0, 8'h00, 1'b0, 1'b1, 8'h81);   // D 1->0->1 mid-cycle
    cycle(1, 1, 1, 8'h81, 1'b0, 1'b1, 8'h81);   // n_rst pulse released before edge
    cycle(1, 0, 0, 8'h12, 1'b1, 1'b1, 8'hEE);   // reset wins over D
    cycle(0, 0, 0, 8'h00, 1'b1, 1'b0, 8'h00);   // reset held again
    cycle(0, 0, 0, 8'h00, 1'b0, 1'b0, 8'hFF);
    cycle(0, 0, 0, 8'h00, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 1) == 1,
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)),
            $urandom_range(0, 3) == 0,
            logic'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CP);
    #3;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
